reg_file_mp: RTL



---
 rtl/reg_file_mp.sv | 101 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enabled writes, optional hardwired
// zero entry and a sequential clear engine. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     clr_req,
    output logic                     ready,
    output logic                     clr_busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_clr_last;
    logic              w_wr_accept;
    logic [DATA_W-1:0] w_wr_old;
    logic [DATA_W-1:0] w_wr_merged;

    assign w_ready     = (r_state == ST_READY);
    assign w_clr_last  = (r_clr_ptr == ADDR_W'(DEPTH - 1));
    assign w_wr_accept = w_ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_wr_old    = r_mem[wr_addr];

    assign ready    = w_ready;
    assign clr_busy = !w_ready;

    always_comb begin
        w_wr_merged = w_wr_old;
        for (int k = 0; k < NBYTES; k++) begin
            if (wr_be[k]) begin
                w_wr_merged[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end

    // Clear walks every entry once; a clear request while already clearing is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (w_clr_last) begin
                r_state <= ST_READY;
            end
        end else if (clr_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

        // Zero masking and the clearing state override any forwarded value.
        always_comb begin
            w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
            if (w_ready && wr_en && (w_addr == wr_addr)) begin
                w_data = w_wr_merged;
            end
`endif
            if (!w_ready || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_data = '0;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = w_data;
    end

endmodule
